// File: rtl/signed_mac_accum.sv
// signed_mac_accum: block accumulator for the signed_mult product stream.
// Sums BLOCK_LEN signed 32-bit products into an ACC_W-bit saturating
// accumulator. The result is held until the consumer takes it.
//   clk, rst       clock, synchronous active-high reset
//   clear          synchronous abort of the current block
//   prod_in/valid  product stream in; prod_ready is the back-pressure
//   acc_full       registered full-width sum; acc_out is acc_full clipped to 32 bits
//   sat_flag       acc_out is clipped; ovf_flag is a sticky accumulator saturation flag
//   term_count     number of products accepted in the current block
//   out_valid/out_ready  result handshake
module signed_mac_accum #(
  parameter int ACC_W     = 40,
  parameter int BLOCK_LEN = 8
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic                           clear,
  input  logic [31:0]                    prod_in,
  input  logic                           prod_valid,
  output logic                           prod_ready,
  output logic [ACC_W-1:0]               acc_full,
  output logic [31:0]                    acc_out,
  output logic                           sat_flag,
  output logic                           ovf_flag,
  output logic [$clog2(BLOCK_LEN+1)-1:0] term_count,
  output logic                           out_valid,
  input  logic                           out_ready
);

  localparam int                CNT_W = $clog2(BLOCK_LEN + 1);
  localparam logic [CNT_W-1:0]  LAST  = CNT_W'(BLOCK_LEN - 1);

  typedef enum logic {ACCUM, HOLD} state_t;

  state_t           state;
  state_t           state_nxt;
  logic             accept;
  logic             last_term;
  logic [ACC_W:0]   sum;
  logic             sum_ovf;
  logic [ACC_W-1:0] sum_sat;
  logic [ACC_W-32:0] upper;
  logic             fits32;

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ACCUM;
    else     state <= state_nxt;
  end

  // Next-state logic; clear overrides both the accept and the handoff
  always_comb begin
    state_nxt = state;
    if (clear) begin
      state_nxt = ACCUM;
    end else begin
      case (state)
        ACCUM:   if (accept && last_term) state_nxt = HOLD;
        HOLD:    if (out_ready)           state_nxt = ACCUM;
        default: state_nxt = ACCUM;
      endcase
    end
  end

  // Output decode
  always_comb begin
    prod_ready = (state == ACCUM) && !clear && !rst;
    out_valid  = (state == HOLD);
  end

  assign accept    = prod_valid && prod_ready;
  assign last_term = (term_count == LAST);

  // One guard bit: overflow shows up as disagreement between the top two bits
  assign sum     = {acc_full[ACC_W-1], acc_full} + {{(ACC_W-31){prod_in[31]}}, prod_in};
  assign sum_ovf = sum[ACC_W] ^ sum[ACC_W-1];

  always_comb begin
    sum_sat = sum[ACC_W-1:0];
    if (sum_ovf) begin
      if (sum[ACC_W]) sum_sat = {1'b1, {(ACC_W-1){1'b0}}};
      else            sum_sat = {1'b0, {(ACC_W-1){1'b1}}};
    end
  end

  // Accumulator datapath; accept is already suppressed by rst/clear/HOLD
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      acc_full   <= '0;
      term_count <= '0;
      ovf_flag   <= 1'b0;
    end else if (state == HOLD) begin
      if (out_ready) begin
        acc_full   <= '0;
        term_count <= '0;
        ovf_flag   <= 1'b0;
      end
    end else if (accept) begin
      acc_full   <= sum_sat;
      term_count <= term_count + CNT_W'(1);
      ovf_flag   <= ovf_flag | sum_ovf;
    end
  end

  // 32-bit view: value fits when bits [ACC_W-1:31] are all copies of the sign
  assign upper  = acc_full[ACC_W-1:31];
  assign fits32 = (&upper) || !(|upper);

  always_comb begin
    acc_out  = acc_full[31:0];
    sat_flag = 1'b0;
    if (!fits32) begin
      sat_flag = 1'b1;
      acc_out  = acc_full[ACC_W-1] ? 32'h8000_0000 : 32'h7FFF_FFFF;
    end
  end

endmodule

// File: tb/tb_signed_mac_accum.sv
// Self-checking bench for signed_mac_accum: a default instance (40-bit, 8 terms)
// and a narrow instance (33-bit, 4 terms) share one stimulus stream; each is
// compared every cycle against an arithmetic block-sum model.
module tb_signed_mac_accum;

  logic        clk;
  logic        rst;
  logic        clear;
  logic [31:0] prod_in;
  logic        prod_valid;
  logic        out_ready;

  logic        b_rdy, b_sat, b_ovf, b_ov;
  logic [39:0] b_acc;
  logic [31:0] b_out;
  logic [3:0]  b_cnt;

  logic        s_rdy, s_sat, s_ovf, s_ov;
  logic [32:0] s_acc;
  logic [31:0] s_out;
  logic [2:0]  s_cnt;

  int passed = 0;
  int total  = 0;

  typedef struct {
    longint acc;
    int     cnt;
    bit     hold;
    bit     ovf;
  } model_t;

  model_t mb;
  model_t ms;

  signed_mac_accum #(.ACC_W(40), .BLOCK_LEN(8)) dut (
    .clk(clk), .rst(rst), .clear(clear), .prod_in(prod_in),
    .prod_valid(prod_valid), .prod_ready(b_rdy), .acc_full(b_acc),
    .acc_out(b_out), .sat_flag(b_sat), .ovf_flag(b_ovf),
    .term_count(b_cnt), .out_valid(b_ov), .out_ready(out_ready)
  );

  signed_mac_accum #(.ACC_W(33), .BLOCK_LEN(4)) dut_small (
    .clk(clk), .rst(rst), .clear(clear), .prod_in(prod_in),
    .prod_valid(prod_valid), .prod_ready(s_rdy), .acc_full(s_acc),
    .acc_out(s_out), .sat_flag(s_sat), .ovf_flag(s_ovf),
    .term_count(s_cnt), .out_valid(s_ov), .out_ready(out_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
  endtask

  // Block-sum model: add, clamp to the signed ACC_W range, count terms.
  function automatic model_t step(input model_t m, input int w, input int blen);
    model_t n;
    longint mx;
    longint mn;
    n  = m;
    mx = (longint'(1) << (w - 1)) - 1;
    mn = -mx - 1;
    if (rst || clear) begin
      n.acc = 0; n.cnt = 0; n.hold = 0; n.ovf = 0;
    end else if (m.hold) begin
      if (out_ready) begin
        n.acc = 0; n.cnt = 0; n.hold = 0; n.ovf = 0;
      end
    end else if (prod_valid) begin
      n.acc = m.acc + longint'($signed(prod_in));
      if (n.acc > mx) begin n.acc = mx; n.ovf = 1; end
      if (n.acc < mn) begin n.acc = mn; n.ovf = 1; end
      n.cnt = m.cnt + 1;
      if (n.cnt == blen) n.hold = 1;
    end
    return n;
  endfunction

  function automatic logic [31:0] clip32(input longint a);
    if (a > 64'sd2147483647)  return 32'h7FFF_FFFF;
    if (a < -64'sd2147483648) return 32'h8000_0000;
    return a[31:0];
  endfunction

  function automatic logic [63:0] accbits(input longint a, input int w);
    logic [63:0] v;
    v = a;
    return v & ((64'd1 << w) - 64'd1);
  endfunction

  task automatic chk_inst(input string p, input model_t m, input int w,
                          input logic [63:0] acc, input logic [31:0] aout,
                          input logic sat, input logic ovf,
                          input logic [7:0] cnt, input logic ov);
    logic [31:0] ec;
    ec = clip32(m.acc);
    chk({p, "_acc_full"}, acc, accbits(m.acc, w));
    chk({p, "_acc_out"}, 64'(aout), 64'(ec));
    chk({p, "_sat_flag"}, 64'(sat), 64'((ec != m.acc[31:0]) ||
        (m.acc > 64'sd2147483647) || (m.acc < -64'sd2147483648)));
    chk({p, "_ovf_flag"}, 64'(ovf), 64'(m.ovf));
    chk({p, "_term_count"}, 64'(cnt), 64'(m.cnt));
    chk({p, "_out_valid"}, 64'(ov), 64'(m.hold));
  endtask

  // One clock: check combinational ready, advance models, check registered outputs.
  task automatic tick();
    #1;
    chk("b_prod_ready", 64'(b_rdy), 64'(!mb.hold && !clear && !rst));
    chk("s_prod_ready", 64'(s_rdy), 64'(!ms.hold && !clear && !rst));
    mb = step(mb, 40, 8);
    ms = step(ms, 33, 4);
    @(posedge clk);
    #1;
    chk_inst("b", mb, 40, 64'(b_acc), b_out, b_sat, b_ovf, 8'(b_cnt), b_ov);
    chk_inst("s", ms, 33, 64'(s_acc), s_out, s_sat, s_ovf, 8'(s_cnt), s_ov);
  endtask

  task automatic feed(input logic [31:0] p, input int n);
    prod_valid = 1'b1;
    prod_in    = p;
    for (int i = 0; i < n; i++) tick();
    prod_valid = 1'b0;
  endtask

  task automatic release_result();
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
  endtask

  initial begin
    mb = '{0, 0, 0, 0};
    ms = '{0, 0, 0, 0};
    rst = 1'b1; clear = 1'b0; prod_in = '0; prod_valid = 1'b0; out_ready = 1'b0;

    // Reset / idle
    tick(); tick();
    rst = 1'b0;
    tick();
    chk("idle_acc", 64'(b_acc), 64'd0);
    chk("idle_ready", 64'(b_rdy), 64'd1);

    // Mixed-sign block
    feed(32'hFFFE_FBB4, 8);
    chk("mix_acc_full", 64'(b_acc), 64'h00_FFFF_F7DD_A0);
    chk("mix_acc_out", 64'(b_out), 64'hFFF7_DDA0);
    chk("mix_valid", 64'(b_ov), 64'd1);
    release_result();

    // 32-bit output saturation
    feed(32'h35A4_E900, 8);
    chk("osat_acc_full", 64'(b_acc), 64'h01_AD27_4800);
    chk("osat_acc_out", 64'(b_out), 64'h7FFF_FFFF);
    chk("osat_sat", 64'(b_sat), 64'd1);
    chk("osat_ovf", 64'(b_ovf), 64'd0);
    release_result();

    // Backpressure: product keeps arriving while the result is held
    prod_valid = 1'b1; prod_in = 32'h4000_0000;
    for (int i = 0; i < 13; i++) tick();
    chk("bp_ready", 64'(b_rdy), 64'd0);
    chk("bp_acc_full", 64'(b_acc), 64'h02_0000_0000);
    out_ready = 1'b1;
    tick();
    out_ready = 1'b0;
    chk("bp_handoff_acc", 64'(b_acc), 64'd0);
    chk("bp_handoff_ready", 64'(b_rdy), 64'd1);
    tick();
    chk("bp_next_accept", 64'(b_cnt), 64'd1);
    prod_valid = 1'b0;

    // Clear mid-block with a product presented
    clear = 1'b1; tick(); clear = 1'b0;
    feed(32'h0000_0001, 3);
    clear = 1'b1; prod_valid = 1'b1; tick(); clear = 1'b0; prod_valid = 1'b0;
    chk("clr_acc", 64'(b_acc), 64'd0);
    chk("clr_cnt", 64'(b_cnt), 64'd0);
    feed(32'h0000_0001, 8);
    chk("clr_fresh_out", 64'(b_out), 64'd8);
    release_result();

    // Accumulator overflow on the narrow instance
    feed(32'h7FFF_FFFF, 4);
    chk("aovf_acc", 64'(s_acc), 64'h0_FFFF_FFFF);
    chk("aovf_flag", 64'(s_ovf), 64'd1);
    chk("aovf_out", 64'(s_out), 64'h7FFF_FFFF);

    // Reset while holding a result
    rst = 1'b1; tick(); rst = 1'b0;
    chk("rst_hold_valid", 64'(s_ov), 64'd0);
    chk("rst_hold_acc", 64'(s_acc), 64'd0);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      prod_valid = ($urandom_range(0, 9) < 7);
      out_ready  = ($urandom_range(0, 2) == 0);
      clear      = ($urandom_range(0, 31) == 0);
      rst        = ($urandom_range(0, 63) == 0);
      case ($urandom_range(0, 3))
        0:       prod_in = $urandom;
        1:       prod_in = 32'h7FFF_FFFF;
        2:       prod_in = 32'h8000_0000;
        default: prod_in = 32'($signed($urandom_range(0, 511)) - 256);
      endcase
      tick();
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/signed_mac_accum.md
Name: signed_mac_accum

Overview:
- Sequential accumulator directly downstream of signed_mult.
- Consumes the 32-bit signed product stream over a valid/ready handshake and sums BLOCK_LEN products into a wide signed accumulator.
- Presents the block result in two forms: full width, and saturated to 32 bits.
- Together with signed_mult, forms the dot-product/MAC path of the arithmetic unit.

Parameters:
- ACC_W, 40: accumulator width in bits, signed two's complement; must be ≥ 33.
- BLOCK_LEN, 8: number of products summed per output block; must be ≥ 1.

Ports:
- clk  input  1  single clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- clear  input  1  synchronous abort; discards the current block and returns to ACCUM.
- prod_in  input  32  signed product from signed_mult (final_signedprod).
- prod_valid  input  1  prod_in is valid this cycle.
- prod_ready  output  1  block can accept prod_in this cycle.
- acc_full  output  ACC_W  registered full-width accumulator value.
- acc_out  output  32  acc_full saturated to the signed 32-bit range.
- sat_flag  output  1  high when acc_out is clipped.
- ovf_flag  output  1  sticky; high if the ACC_W accumulator itself saturated during the current block.
- term_count  output  $clog2(BLOCK_LEN+1)  number of products accepted in the current block.
- out_valid  output  1  block result valid.
- out_ready  input  1  consumer accepts the result.

Behaviour:
- Reset: rst is synchronous and active-high; the clock is clk. When rst is sampled high:
  - state = ACCUM;
  - acc_full = 0, acc_out = 0, term_count = 0;
  - sat_flag = 0, ovf_flag = 0, out_valid = 0.
  - rst has priority over all other inputs.
- States:
  - ACCUM: out_valid = 0.
  - HOLD: out_valid = 1, prod_ready = 0.
- prod_ready: combinational, equal to (state==ACCUM) & ~clear & ~rst.
- Accept event: prod_valid & prod_ready. In ACCUM, on an accept:
  - acc_full <= sat_ACC_W(acc_full + sign_extend(prod_in)), computed with ACC_W+1 bits internally;
  - on saturation, clamp to ±(2^(ACC_W-1)) bounds (max positive / min negative) and set ovf_flag;
  - term_count increments.
- Block completion: an accept when term_count == BLOCK_LEN-1 moves to HOLD. out_valid rises the cycle after the final accept, so latency is 1 cycle from last product to result.
- HOLD:
  - acc_full, term_count (= BLOCK_LEN) and the flags are frozen.
  - prod_valid is ignored; no product is lost because prod_ready is low.
- Output handshake: in HOLD, when out_ready is sampled high:
  - acc_full, term_count and ovf_flag are zeroed;
  - state returns to ACCUM;
  - prod_ready is high the next cycle.
  - There is no bypass: a product cannot be accepted in the same cycle as the result handoff.
- out_ready while in ACCUM: ignored.
- acc_out / sat_flag: derived from registered acc_full (not combinational from prod_in).
  - acc_full > 2^31-1 → acc_out = 0x7FFFFFFF, sat_flag = 1.
  - acc_full < -2^31 → acc_out = 0x80000000, sat_flag = 1.
  - otherwise acc_out = acc_full[31:0], sat_flag = 0.
- clear: takes priority over accept and over out_ready.
  - Next state = ACCUM; acc_full, term_count and flags = 0; out_valid = 0.
  - A product presented in the same cycle as clear is not accepted.
- Reset mid-block or in HOLD: behaves as clear; the partial or pending result is discarded.
- BLOCK_LEN = 1: every accepted product goes directly to HOLD.

Test Plan:
- Reset/idle: rst high 2 cycles then low, prod_valid = 0 → acc_full = 0, acc_out = 0, out_valid = 0, prod_ready = 1, term_count = 0.
- Mixed-sign block: 8 products of 0xFFFEFBB4 (-1234×54 = -66636) on consecutive cycles → out_valid = 1 one cycle after the 8th; acc_full = -533088 (0xFFFFF7DDA0 in 40 bits); acc_out = 0xFFF7DDA0; sat_flag = 0.
- Output saturation: 8× 0x35A4E900 (30000×30000) → acc_full = 0x01AD274800; acc_out = 0x7FFFFFFF; sat_flag = 1; ovf_flag = 0.
- Backpressure: complete a block of 8× 0x40000000 with out_ready = 0 for 5 cycles while prod_valid stays high → prod_ready = 0; acc_full stays 0x0200000000. Then assert out_ready → next cycle state = ACCUM, acc_full = 0, and the next product is accepted the following cycle.
- Clear mid-block: accept 3× 0x00000001, then assert clear together with prod_valid → the next cycle has acc_full = 0 and term_count = 0, and that product is dropped. A fresh block of 8× 1 then yields acc_out = 8.
- Accumulator overflow: ACC_W = 33, BLOCK_LEN = 4, 4× 0x7FFFFFFF → acc_full clamps at 2^32-1; ovf_flag = 1; acc_out = 0x7FFFFFFF.
